mult_div_unit: RTL and testbench

Multicycle signed multiply/divide unit for the MIPS datapath. It owns the architectural HI and LO registers and executes `mult` and `div` over 32+ cycles under a start/done handshake from the control FSM. Its `hi` and `lo` outputs feed the HI and LO inputs of the register-file write-back selector directly.

---
 rtl/mult_div_pkg.sv | 28 ++
 rtl/mult_div_divcore.sv | 62 ++++++
 rtl/mult_div_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared constants, state encoding and sign helpers for the multiply/divide unit.
package mult_div_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MD_ITERS = 32;
    localparam int CNT_W    = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITERS - 1);

    localparam logic [31:0] HILO_RST = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MULT    = 2'd1,
        ST_DIV     = 2'd2,
        ST_DIV_FIX = 2'd3
    } md_state_e;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return cond_neg(v, v[31]);
    endfunction

endpackage

// File: rtl/mult_div_divcore.sv
// Restoring divider on operand magnitudes with sign fix-up of quotient and remainder.
module mult_div_divcore
    import mult_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_quo,
    output logic [31:0] o_rem
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;

    // Trial subtraction of the shifted partial remainder.
    always_comb begin
        w_rem_sh = {r_rem, r_quo[31]};
        w_diff   = w_rem_sh - {1'b0, r_dvs};
    end

    // Operand load and one quotient bit per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= 32'h0000_0000;
            r_quo   <= 32'h0000_0000;
            r_dvs   <= 32'h0000_0000;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_load) begin
            r_rem   <= 32'h0000_0000;
            r_quo   <= mag32(i_a);
            r_dvs   <= mag32(i_b);
            r_neg_q <= i_a[31] ^ i_b[31];
            r_neg_r <= i_a[31];
        end else if (i_step) begin
            if (!w_diff[32]) begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_rem_sh[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
        end else begin
            r_rem <= r_rem;
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend sign.
    always_comb begin
        o_quo = cond_neg(r_quo, r_neg_q);
        o_rem = cond_neg(r_rem, r_neg_r);
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed mult/div unit owning HI/LO; the divider is built only when
// MULT_DIV_DIV_EN is defined, otherwise a divide request completes as a no-op.
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [32:0]      r_acc;
    logic [31:0]      r_mq;
    logic             r_q_1;
    logic [31:0]      r_mcand;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;
    logic             r_done;
    logic [32:0]      w_acc_add;
    logic             w_accept;
    logic             w_mult_go;
    logic             w_wr_mult;
    logic             w_fin;
`ifdef MULT_DIV_DIV_EN
    logic             w_div_go;
    logic             w_div_by0;
    logic             w_wr_div;
    logic [31:0]      w_quo;
    logic [31:0]      w_rem;
    logic             r_div_zero;
`endif

    // Next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mult_go   = 1'b0;
        w_wr_mult   = 1'b0;
        w_fin       = 1'b0;
`ifdef MULT_DIV_DIV_EN
        w_div_go    = 1'b0;
        w_div_by0   = 1'b0;
        w_wr_div    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (op == OP_MULT) begin
                        w_state_nxt = ST_MULT;
                        w_mult_go   = 1'b1;
                    end else begin
`ifdef MULT_DIV_DIV_EN
                        if (b == 32'h0000_0000) begin
                            w_div_by0 = 1'b1;
                            w_fin     = 1'b1;
                        end else begin
                            w_state_nxt = ST_DIV;
                            w_div_go    = 1'b1;
                        end
`else
                        w_fin = 1'b1;
`endif
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MULT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_wr_mult   = 1'b1;
                    w_fin       = 1'b1;
                end else begin
                    w_state_nxt = ST_MULT;
                end
            end
`ifdef MULT_DIV_DIV_EN
            ST_DIV: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_DIV_FIX;
                end else begin
                    w_state_nxt = ST_DIV;
                end
            end
            ST_DIV_FIX: begin
                w_state_nxt = ST_IDLE;
                w_wr_div    = 1'b1;
                w_fin       = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Step counter shared by the Booth and restoring iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == ST_MULT || r_state == ST_DIV) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Booth add/subtract; a 33-bit accumulator absorbs the -2^31 multiplicand.
    always_comb begin
        case ({r_mq[0], r_q_1})
            2'b01:   w_acc_add = r_acc + {r_mcand[31], r_mcand};
            2'b10:   w_acc_add = r_acc - {r_mcand[31], r_mcand};
            default: w_acc_add = r_acc;
        endcase
    end

    // Booth datapath: load, then arithmetic shift right once per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= 33'h0_0000_0000;
            r_mq    <= 32'h0000_0000;
            r_q_1   <= 1'b0;
            r_mcand <= 32'h0000_0000;
        end else if (w_mult_go) begin
            r_acc   <= 33'h0_0000_0000;
            r_mq    <= b;
            r_q_1   <= 1'b0;
            r_mcand <= a;
        end else if (r_state == ST_MULT) begin
            r_acc   <= {w_acc_add[32], w_acc_add[32:1]};
            r_mq    <= {w_acc_add[0], r_mq[31:1]};
            r_q_1   <= r_mq[0];
        end else begin
            r_acc   <= r_acc;
        end
    end

`ifdef MULT_DIV_DIV_EN
    mult_div_divcore u_divcore (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_div_go),
        .i_step (r_state == ST_DIV),
        .i_a    (a),
        .i_b    (b),
        .o_quo  (w_quo),
        .o_rem  (w_rem)
    );

    // Divide-by-zero flag, refreshed by every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_div_zero <= w_div_by0;
        end else begin
            r_div_zero <= r_div_zero;
        end
    end

    assign div_zero = r_div_zero;
`else
    assign div_zero = 1'b0;
`endif

    // Architectural HI/LO, written only on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= HILO_RST;
            r_lo <= HILO_RST;
        end else if (w_wr_mult) begin
            r_hi <= w_acc_add[32:1];
            r_lo <= {w_acc_add[0], r_mq[31:1]};
`ifdef MULT_DIV_DIV_EN
        end else if (w_wr_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
`endif
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end

    // Handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= w_fin;
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, random ops against an
// arithmetic reference, ignored-start and mid-operation reset sequences.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_checks;
    int n_fail;

    logic [31:0] cur_hi;
    logic [31:0] cur_lo;
    bit          cur_dz;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
        int          lat;
        bit          b2b;
    } vec_t;

    vec_t tbl[8];

    mult_div_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output bit edz, output int lat);
        longint p;
        eh  = cur_hi;
        el  = cur_lo;
        edz = 1'b0;
        lat = 1;
        if (o == 1'b0) begin
            p   = longint'($signed(x)) * longint'($signed(y));
            eh  = p[63:32];
            el  = p[31:0];
            lat = 33;
        end else begin
`ifdef MULT_DIV_DIV_EN
            if (y == 32'h0) begin
                edz = 1'b1;
            end else begin
                longint q;
                longint r;
                q   = longint'($signed(x)) / longint'($signed(y));
                r   = longint'($signed(x)) % longint'($signed(y));
                eh  = r[31:0];
                el  = q[31:0];
                lat = 34;
            end
`endif
        end
    endfunction

    // Called #1 after a rising edge; that cycle becomes cycle 0. Returns in the done cycle.
    task automatic do_op(input string nm, input logic o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input bit edz,
                         input int lat, input int inj);
        int got;
        bit busy_ok;
        bit hold_ok;
        bit dz_ok;
        chk({nm, "_dz_before"}, 64'(div_zero), 64'(cur_dz));
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        got     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        dz_ok   = 1'b1;
        for (int k = 1; k <= 60 && got == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (inj != 0 && k == inj) begin
                start = 1'b1;
                op    = 1'b0;
                a     = 32'hFFFF_FFFF;
                b     = 32'h0000_0007;
            end else if (inj != 0 && k == inj + 1) begin
                start = 1'b0;
            end
            if (div_zero !== edz) dz_ok = 1'b0;
            if (done === 1'b1) begin
                got = k;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (hi !== cur_hi || lo !== cur_lo) hold_ok = 1'b0;
            end
        end
        chk({nm, "_done_cycle"}, 64'(got), 64'(lat));
        chk({nm, "_busy_run"}, 64'(busy_ok), 64'd1);
        chk({nm, "_hilo_hold"}, 64'(hold_ok), 64'd1);
        chk({nm, "_div_zero"}, 64'(dz_ok), 64'd1);
        if (got != 0) begin
            chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
            chk({nm, "_hi"}, 64'(hi), 64'(eh));
            chk({nm, "_lo"}, 64'(lo), 64'(el));
        end
        cur_hi = eh;
        cur_lo = el;
        cur_dz = edz;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cur_hi   = 32'h0;
        cur_lo   = 32'h0;
        cur_dz   = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 1'b0;
        a        = 32'h0;
        b        = 32'h0;

        tbl[0] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b0};
        tbl[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001, 1'b0, 33, 1'b1};
`ifdef MULT_DIV_DIV_EN
        tbl[3] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b0};
        tbl[4] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34, 1'b0};
        tbl[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34, 1'b0};
        tbl[6] = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1, 1'b0};
`else
        tbl[3] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0000, 32'hFFFE_0001, 1'b0, 1, 1'b0};
        tbl[4] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFE_0001, 1'b0, 1, 1'b0};
        tbl[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFE_0001, 1'b0, 1, 1'b0};
        tbl[6] = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'hFFFE_0001, 1'b0, 1, 1'b0};
`endif
        tbl[7] = '{1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0, 33, 1'b0};

        #2;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            if (i > 0 && !tbl[i].b2b) idle_cycle();
            do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].lat, 0);
        end

        for (int i = 0; i < 24; i++) begin
            logic        o;
            logic [31:0] x;
            logic [31:0] y;
            logic [31:0] eh;
            logic [31:0] el;
            bit          edz;
            int          lat;
            o = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       x = 32'h8000_0000;
                1:       x = 32'($urandom_range(0, 20)) - 32'd10;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       y = 32'h0000_0000;
                1:       y = 32'hFFFF_FFFF;
                2:       y = 32'($urandom_range(0, 20)) - 32'd10;
                default: y = $urandom;
            endcase
            model(o, x, y, eh, el, edz, lat);
            if ($urandom_range(0, 1) == 0) idle_cycle();
            do_op($sformatf("rnd%0d", i), o, x, y, eh, el, edz, lat, 0);
        end

        begin
            logic [31:0] eh;
            logic [31:0] el;
            bit          edz;
            int          lat;
            idle_cycle();
            model(1'b0, 32'h0001_2345, 32'hFFFF_5678, eh, el, edz, lat);
            do_op("ignored_start", 1'b0, 32'h0001_2345, 32'hFFFF_5678, eh, el, edz, lat, 10);
        end

        begin
            bit quiet;
            idle_cycle();
            start = 1'b1;
`ifdef MULT_DIV_DIV_EN
            op = 1'b1;
`else
            op = 1'b0;
`endif
            a = 32'h0000_0064;
            b = 32'h0000_0003;
            for (int k = 1; k <= 15; k++) begin
                @(posedge clk);
                #1;
                if (k == 1) start = 1'b0;
            end
            rst_n = 1'b0;
            #1;
            chk("midrst_hi", 64'(hi), 64'd0);
            chk("midrst_lo", 64'(lo), 64'd0);
            chk("midrst_busy", 64'(busy), 64'd0);
            chk("midrst_done", 64'(done), 64'd0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            quiet = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            end
            chk("midrst_no_done", 64'(quiet), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
